// File: rtl/pss_tracker_if.sv
// Detector-side signal bundle for pss_tracker: sample strobe and detections in, mode/ID/lock/timing out.
interface pss_tracker_if #(
    parameter int unsigned SSB_INTERVAL    = 38400,
    parameter int unsigned TRACK_TOLERANCE = 100,
    parameter int unsigned MAX_MISSES      = 3
);
    localparam int unsigned CNT_W  = $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1);
    localparam int unsigned MISS_W = $clog2(MAX_MISSES + 1);

    logic              s_axis_in_tvalid;
    logic [1:0]        N_id_2_i;
    logic              N_id_2_valid_i;
    logic [1:0]        mode_o;
    logic [1:0]        requested_N_id_2_o;
    logic [1:0]        N_id_2_o;
    logic              locked_o;
    logic              ssb_start_o;
    logic [CNT_W-1:0]  sample_cnt_o;
    logic [MISS_W-1:0] miss_cnt_o;

    modport master (
        output s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
        input  mode_o, requested_N_id_2_o, N_id_2_o, locked_o,
               ssb_start_o, sample_cnt_o, miss_cnt_o
    );

    modport slave (
        input  s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
        output mode_o, requested_N_id_2_o, N_id_2_o, locked_o,
               ssb_start_o, sample_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/pss_tracker.sv
// PSS SSB timing tracker: SEARCH -> WAIT -> WINDOW flywheel with loss-of-lock after repeated misses.
// Optional macro PSS_TRACKER_STATS_EN adds saturating detect/lost counters.
module pss_tracker #(
    parameter int unsigned SSB_INTERVAL    = 38400,
    parameter int unsigned TRACK_TOLERANCE = 100,
    parameter int unsigned MAX_MISSES      = 3
) (
    input  logic           clk_i,
    input  logic           reset_i,
    pss_tracker_if.slave   bus
`ifdef PSS_TRACKER_STATS_EN
    ,
    output logic [15:0]    detect_cnt_o,
    output logic [15:0]    lost_cnt_o
`endif
);
    localparam int unsigned CNT_W  = $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1);
    localparam int unsigned MISS_W = $clog2(MAX_MISSES + 1);

    localparam logic [CNT_W-1:0]  L_OPEN  = CNT_W'(SSB_INTERVAL - TRACK_TOLERANCE);
    localparam logic [CNT_W-1:0]  L_CLOSE = CNT_W'(SSB_INTERVAL + TRACK_TOLERANCE);
    localparam logic [CNT_W-1:0]  L_TOL   = CNT_W'(TRACK_TOLERANCE);
    localparam logic [MISS_W-1:0] L_MAXM  = MISS_W'(MAX_MISSES);

    localparam logic [1:0] MODE_SEARCH = 2'd0;
    localparam logic [1:0] MODE_FIND   = 2'd1;
    localparam logic [1:0] MODE_PAUSE  = 2'd2;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_WAIT   = 2'd1,
        ST_WINDOW = 2'd2
    } state_t;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [1:0]        r_req_id;
    logic [1:0]        r_nid;
    logic              r_locked;
    logic              r_ssb_start;
    logic [CNT_W-1:0]  r_cnt;
    logic [MISS_W-1:0] r_miss;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic [MISS_W-1:0] w_miss_inc;
    logic              w_hit;
    logic              w_expire;

    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_miss_inc = r_miss + MISS_W'(1);
    assign w_hit      = bus.N_id_2_valid_i && (bus.N_id_2_i == r_nid);
    assign w_expire   = bus.s_axis_in_tvalid && (w_cnt_inc == L_CLOSE);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_SEARCH;
            r_mode      <= MODE_SEARCH;
            r_req_id    <= 2'd0;
            r_nid       <= 2'd0;
            r_locked    <= 1'b0;
            r_ssb_start <= 1'b0;
            r_cnt       <= '0;
            r_miss      <= '0;
        end else begin
            r_ssb_start <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    r_cnt <= '0;
                    if (bus.N_id_2_valid_i) begin
                        r_nid       <= bus.N_id_2_i;
                        r_req_id    <= bus.N_id_2_i;
                        r_miss      <= '0;
                        r_ssb_start <= 1'b1;
                        r_locked    <= 1'b1;
                        r_mode      <= MODE_PAUSE;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.s_axis_in_tvalid) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == L_OPEN) begin
                            r_req_id <= r_nid;
                            r_mode   <= MODE_FIND;
                            r_state  <= ST_WINDOW;
                        end
                    end
                end
                ST_WINDOW: begin
                    // A matching detection outranks both the increment and expiry.
                    if (w_hit) begin
                        r_cnt       <= '0;
                        r_miss      <= '0;
                        r_ssb_start <= 1'b1;
                        r_mode      <= MODE_PAUSE;
                        r_state     <= ST_WAIT;
                    end else if (w_expire) begin
                        if (w_miss_inc == L_MAXM) begin
                            r_cnt    <= '0;
                            r_miss   <= '0;
                            r_locked <= 1'b0;
                            r_mode   <= MODE_SEARCH;
                            r_state  <= ST_SEARCH;
                        end else begin
                            // Flywheel: pretend the SSB landed at its nominal position.
                            r_cnt   <= L_TOL;
                            r_miss  <= w_miss_inc;
                            r_mode  <= MODE_PAUSE;
                            r_state <= ST_WAIT;
                        end
                    end else if (bus.s_axis_in_tvalid) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt    <= '0;
                    r_miss   <= '0;
                    r_locked <= 1'b0;
                    r_mode   <= MODE_SEARCH;
                    r_state  <= ST_SEARCH;
                end
            endcase
        end
    end

    assign bus.mode_o             = r_mode;
    assign bus.requested_N_id_2_o = r_req_id;
    assign bus.N_id_2_o           = r_nid;
    assign bus.locked_o           = r_locked;
    assign bus.ssb_start_o        = r_ssb_start;
    assign bus.sample_cnt_o       = r_cnt;
    assign bus.miss_cnt_o         = r_miss;

`ifdef PSS_TRACKER_STATS_EN
    logic [15:0] r_detect_cnt;
    logic [15:0] r_lost_cnt;
    logic        w_accept;
    logic        w_lose;

    assign w_accept = ((r_state == ST_SEARCH) && bus.N_id_2_valid_i) ||
                      ((r_state == ST_WINDOW) && w_hit);
    assign w_lose   = (r_state == ST_WINDOW) && !w_hit && w_expire && (w_miss_inc == L_MAXM);

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_detect_cnt <= 16'd0;
            r_lost_cnt   <= 16'd0;
        end else begin
            if (w_accept && (r_detect_cnt != 16'hFFFF)) r_detect_cnt <= r_detect_cnt + 16'd1;
            if (w_lose && (r_lost_cnt != 16'hFFFF))     r_lost_cnt   <= r_lost_cnt + 16'd1;
        end
    end

    assign detect_cnt_o = r_detect_cnt;
    assign lost_cnt_o   = r_lost_cnt;
`endif
endmodule

// File: tb/tb_pss_tracker.sv
// Self-checking bench for pss_tracker: directed scenarios then random traffic against a phase-from-count model.
module tb_pss_tracker;
    localparam int unsigned SSB   = 1000;
    localparam int unsigned TOL   = 10;
    localparam int unsigned MAXM  = 2;
    localparam int          OPEN  = SSB - TOL;
    localparam int          CLOSE = SSB + TOL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pss_tracker_if #(.SSB_INTERVAL(SSB), .TRACK_TOLERANCE(TOL), .MAX_MISSES(MAXM)) bus ();

`ifdef PSS_TRACKER_STATS_EN
    logic [15:0] detect_cnt;
    logic [15:0] lost_cnt;
`endif

    pss_tracker #(.SSB_INTERVAL(SSB), .TRACK_TOLERANCE(TOL), .MAX_MISSES(MAXM)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
`ifdef PSS_TRACKER_STATS_EN
        ,
        .detect_cnt_o (detect_cnt),
        .lost_cnt_o   (lost_cnt)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference: lock flag plus samples since the SSB reference; the window is implied by the count.
    int m_locked = 0, m_cnt = 0, m_miss = 0, m_nid = 0, m_pulse = 0, m_det = 0, m_lost = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_mode();
        if (m_locked == 0) return 0;
        return (m_cnt >= OPEN) ? 1 : 2;
    endfunction

    task automatic model_step(input bit r, input bit tv, input bit v, input int id);
        m_pulse = 0;
        if (r) begin
            m_locked = 0; m_cnt = 0; m_miss = 0; m_nid = 0; m_det = 0; m_lost = 0;
        end else if (m_locked == 0) begin
            m_cnt = 0;
            if (v) begin
                m_locked = 1; m_nid = id; m_cnt = 0; m_miss = 0; m_pulse = 1;
                if (m_det < 65535) m_det++;
            end
        end else if (m_cnt >= OPEN) begin
            if (v && id == m_nid) begin
                m_cnt = 0; m_miss = 0; m_pulse = 1;
                if (m_det < 65535) m_det++;
            end else if (tv) begin
                if (m_cnt + 1 == CLOSE) begin
                    if (m_miss + 1 == MAXM) begin
                        m_locked = 0; m_cnt = 0; m_miss = 0;
                        if (m_lost < 65535) m_lost++;
                    end else begin
                        m_miss++; m_cnt = TOL;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end else if (tv) begin
            m_cnt++;
        end
    endtask

    task automatic step(input bit r, input bit tv, input bit v, input int id);
        rst                  = r;
        bus.s_axis_in_tvalid = tv;
        bus.N_id_2_valid_i   = v;
        bus.N_id_2_i         = 2'(id);
        @(posedge clk);
        model_step(r, tv, v, id);
        #1;
        check_eq("mode",   int'(bus.mode_o), exp_mode());
        check_eq("locked", int'(bus.locked_o), m_locked);
        check_eq("nid",    int'(bus.N_id_2_o), m_nid);
        check_eq("req",    int'(bus.requested_N_id_2_o), m_nid);
        check_eq("pulse",  int'(bus.ssb_start_o), m_pulse);
        check_eq("cnt",    int'(bus.sample_cnt_o), m_cnt);
        check_eq("miss",   int'(bus.miss_cnt_o), m_miss);
`ifdef PSS_TRACKER_STATS_EN
        check_eq("det_cnt",  int'(detect_cnt), m_det);
        check_eq("lost_cnt", int'(lost_cnt), m_lost);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.s_axis_in_tvalid = 1'b1;
        bus.N_id_2_valid_i   = 1'b0;
        bus.N_id_2_i         = 2'd0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0);
        check_eq("rst_mode",   int'(bus.mode_o), 0);
        check_eq("rst_locked", int'(bus.locked_o), 0);
        check_eq("rst_cnt",    int'(bus.sample_cnt_o), 0);

        // Acquire ID 2, window opens 990 samples later.
        step(1'b0, 1'b1, 1'b1, 2);
        check_eq("acq_mode",   int'(bus.mode_o), 2);
        check_eq("acq_locked", int'(bus.locked_o), 1);
        check_eq("acq_nid",    int'(bus.N_id_2_o), 2);
        check_eq("acq_req",    int'(bus.requested_N_id_2_o), 2);
        check_eq("acq_pulse",  int'(bus.ssb_start_o), 1);
        idle(1);
        check_eq("acq_pulse_once", int'(bus.ssb_start_o), 0);
        idle(988);
        check_eq("pre_window_mode", int'(bus.mode_o), 2);
        idle(1);
        check_eq("window_mode", int'(bus.mode_o), 1);

        // Track five periods with detections 1003 samples apart.
        idle(12);
        for (int p = 0; p < 5; p++) begin
            if (p != 0) idle(1002);
            step(1'b0, 1'b1, 1'b1, 2);
            check_eq("trk_cnt",    int'(bus.sample_cnt_o), 0);
            check_eq("trk_pulse",  int'(bus.ssb_start_o), 1);
            check_eq("trk_mode",   int'(bus.mode_o), 2);
            check_eq("trk_locked", int'(bus.locked_o), 1);
        end

        // Wrong ID in window is ignored, expiry flywheels.
        idle(1005);
        step(1'b0, 1'b1, 1'b1, 1);
        check_eq("wrong_id_mode", int'(bus.mode_o), 1);
        idle(3);
        check_eq("pre_expiry_cnt", int'(bus.sample_cnt_o), 1009);
        idle(1);
        check_eq("fly_miss",  int'(bus.miss_cnt_o), 1);
        check_eq("fly_cnt",   int'(bus.sample_cnt_o), 10);
        check_eq("fly_mode",  int'(bus.mode_o), 2);
        check_eq("fly_pulse", int'(bus.ssb_start_o), 0);

        // Correct detection on the exact expiry cycle wins.
        idle(999);
        step(1'b0, 1'b1, 1'b1, 2);
        check_eq("edge_pulse", int'(bus.ssb_start_o), 1);
        check_eq("edge_cnt",   int'(bus.sample_cnt_o), 0);
        check_eq("edge_miss",  int'(bus.miss_cnt_o), 0);

        // Two misses in a row drop lock.
        idle(1010);
        check_eq("miss1", int'(bus.miss_cnt_o), 1);
        idle(1000);
        check_eq("lost_mode",   int'(bus.mode_o), 0);
        check_eq("lost_locked", int'(bus.locked_o), 0);
        check_eq("lost_miss",   int'(bus.miss_cnt_o), 0);

        // Sample gap in WAIT delays the window by the gap length.
        step(1'b0, 1'b1, 1'b1, 2);
        idle(500);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 0);
        check_eq("gap_cnt", int'(bus.sample_cnt_o), 500);
        idle(489);
        check_eq("gap_pre_mode", int'(bus.mode_o), 2);
        idle(1);
        check_eq("gap_win_mode", int'(bus.mode_o), 1);

        // Reset mid-window.
        idle(5);
        step(1'b1, 1'b1, 1'b0, 0);
        check_eq("mrst_mode",   int'(bus.mode_o), 0);
        check_eq("mrst_locked", int'(bus.locked_o), 0);
        check_eq("mrst_nid",    int'(bus.N_id_2_o), 0);
        check_eq("mrst_cnt",    int'(bus.sample_cnt_o), 0);

        // Random traffic.
        for (int i = 0; i < 30000; i++) begin
            step($urandom_range(0, 4999) == 0,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
